// File: rtl/jtframe_sim_trigger.sv
// Frame counter and dump-window controller for simulation benches: counts vs falls
// after ROM download, opens/closes the dump window and raises a sticky finish request.
module jtframe_sim_trigger #(
    parameter bit          WAIT_DWNLD  = 1'b1,
    parameter logic [31:0] DUMP_START  = 32'd0,
    parameter logic [31:0] DUMP_FRAMES = 32'd0,
    parameter logic [31:0] MAX_FRAMES  = 32'd0,
    parameter logic [31:0] FRAME_INIT  = 32'd0,
    localparam int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vs,
    input  logic             downloading,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             dump_on,
    output logic             dump_start,
    output logic             dump_stop,
    output logic             sim_finish
);

    typedef enum logic [1:0] {
        ST_WAIT_DL = 2'd0,
        ST_COUNT   = 2'd1,
        ST_DUMP    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam state_t RST_STATE = WAIT_DWNLD ? ST_WAIT_DL : ST_COUNT;

    state_t           state_q, state_d;
    logic             vs_l_q, vs_l_d;
    logic             dl_l_q, dl_l_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] dump_len_q, dump_len_d;
    logic             dump_on_q, dump_on_d;
    logic             dump_start_q, dump_start_d;
    logic             dump_stop_q, dump_stop_d;
    logic             sim_finish_q, sim_finish_d;

    logic             vs_fall;
    logic             dl_fall;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len_inc;
    logic             hit_finish;
    logic             hit_start;
    logic             hit_end;

    // Next-state and output logic; finish takes priority over window start/end
    always_comb begin
        state_d      = state_q;
        vs_l_d       = vs;
        dl_l_d       = downloading;
        frame_cnt_d  = frame_cnt_q;
        dump_len_d   = dump_len_q;
        dump_on_d    = dump_on_q;
        dump_start_d = 1'b0;
        dump_stop_d  = 1'b0;
        sim_finish_d = sim_finish_q;

        vs_fall    = vs_l_q & ~vs;
        dl_fall    = dl_l_q & ~downloading;
        cnt_inc    = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + CNT_W'(1);
        len_inc    = (&dump_len_q) ? dump_len_q : dump_len_q + CNT_W'(1);
        hit_finish = (MAX_FRAMES != CNT_W'(0)) && (cnt_inc == MAX_FRAMES);
        hit_start  = (frame_cnt_q == DUMP_START);
        hit_end    = (DUMP_FRAMES != CNT_W'(0)) && (len_inc == DUMP_FRAMES);

        case (state_q)
            ST_WAIT_DL: begin
                if (dl_fall) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (vs_fall) begin
                    frame_cnt_d = cnt_inc;
                    if (hit_finish) begin
                        state_d      = ST_DONE;
                        sim_finish_d = 1'b1;
                    end else if (hit_start) begin
                        state_d      = ST_DUMP;
                        dump_on_d    = 1'b1;
                        dump_start_d = 1'b1;
                        dump_len_d   = CNT_W'(0);
                    end
                end
            end
            ST_DUMP: begin
                if (vs_fall) begin
                    frame_cnt_d = cnt_inc;
                    dump_len_d  = len_inc;
                    if (hit_finish) begin
                        state_d      = ST_DONE;
                        sim_finish_d = 1'b1;
                        dump_on_d    = 1'b0;
                        dump_stop_d  = 1'b1;
                    end else if (hit_end) begin
                        state_d     = ST_COUNT;
                        dump_on_d   = 1'b0;
                        dump_stop_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RST_STATE;
            vs_l_q       <= 1'b0;
            dl_l_q       <= 1'b0;
            frame_cnt_q  <= FRAME_INIT;
            dump_len_q   <= CNT_W'(0);
            dump_on_q    <= 1'b0;
            dump_start_q <= 1'b0;
            dump_stop_q  <= 1'b0;
            sim_finish_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_l_q       <= vs_l_d;
            dl_l_q       <= dl_l_d;
            frame_cnt_q  <= frame_cnt_d;
            dump_len_q   <= dump_len_d;
            dump_on_q    <= dump_on_d;
            dump_start_q <= dump_start_d;
            dump_stop_q  <= dump_stop_d;
            sim_finish_q <= sim_finish_d;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign dump_on    = dump_on_q;
    assign dump_start = dump_start_q;
    assign dump_stop  = dump_stop_q;
    assign sim_finish = sim_finish_q;

endmodule
